// File: rtl/framebuffer_reader.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_reader
//  Purpose  : Streams 2-bit pixel codes for a rectangular sprite window out of
//             a 32-bit-wide pixel memory, one pixel per clock, one clock after
//             the scan position is presented. A single prefetch buffer is
//             kept one word ahead of the shift register so that memory
//             latency is hidden behind the 16 clocks it takes to shift out
//             one word.
//
//  Ports    : i_Clk          - clock, all state on the rising edge
//             i_Reset        - synchronous active-high reset
//             i_Row/i_Column - current scan position from the VGA timing
//             o_Rd_Req       - read request, held until i_Rd_Valid
//             o_Rd_Addr      - word address, stable while o_Rd_Req is high
//             i_Rd_Valid     - one-cycle completion pulse for the request
//             i_Rd_Data      - read word, leftmost pixel in [31:30]
//             o_Pixel        - pixel code for the previous cycle's position
//             o_Pixel_Valid  - previous cycle's position was inside window
//             o_Underrun     - sticky: a word was needed before it arrived
//
//  Revision : 1.0 - initial release
// ============================================================================
module framebuffer_reader #(
    parameter int X_START = 16,
    parameter int WIDTH   = 256,
    parameter int HEIGHT  = 256
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [9:0]  i_Row,
    input  logic [9:0]  i_Column,
    output logic        o_Rd_Req,
    output logic [11:0] o_Rd_Addr,
    input  logic        i_Rd_Valid,
    input  logic [31:0] i_Rd_Data,
    output logic [1:0]  o_Pixel,
    output logic        o_Pixel_Valid,
    output logic        o_Underrun
);

    localparam int                 c_TOTAL_INT = HEIGHT * WIDTH / 16;
    localparam int                 c_CNT_W     = $clog2(c_TOTAL_INT + 1);
    localparam logic [c_CNT_W-1:0] c_TOTAL     = c_CNT_W'(c_TOTAL_INT);

    // Window bounds widened by one bit so that X_START+WIDTH may reach 1024.
    localparam logic [10:0] c_X_LO    = 11'(X_START);
    localparam logic [10:0] c_X_HI    = 11'(X_START + WIDTH);
    localparam logic [10:0] c_Y_HI    = 11'(HEIGHT);
    localparam logic [3:0]  c_X_PHASE = 4'(X_START);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_State;
    logic [c_CNT_W-1:0] r_Fetch_Cnt;
    logic [31:0]        r_PB;
    logic               r_PB_Full;
    logic               r_Discard;
    logic [31:0]        r_SR;

    logic               w_Active;
    logic [3:0]         w_Offset_Lo;
    logic               w_Word_Start;
    logic               w_Resync;
    logic               w_Consume;
    logic [11:0]        w_Next_Addr;

    // Only the low nibble of the window offset matters: it marks word starts.
    assign w_Offset_Lo  = i_Column[3:0] - c_X_PHASE;
    assign w_Active     = ({1'b0, i_Row} < c_Y_HI) &&
                          ({1'b0, i_Column} >= c_X_LO) &&
                          ({1'b0, i_Column} <  c_X_HI);
    assign w_Word_Start = w_Active && (w_Offset_Lo == 4'd0);
    assign w_Resync     = ({1'b0, i_Row} == c_Y_HI) && (i_Column == 10'd0);
    assign w_Consume    = w_Word_Start && r_PB_Full;
    assign w_Next_Addr  = 12'(r_Fetch_Cnt);

    // ------------------------------------------------------------------
    // Pixel path: shift register fed from the prefetch buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_SR          <= 32'd0;
            o_Pixel       <= 2'd0;
            o_Pixel_Valid <= 1'b0;
            o_Underrun    <= 1'b0;
        end else if (w_Word_Start) begin
            o_Pixel_Valid <= 1'b1;
            if (r_PB_Full) begin
                r_SR    <= r_PB;
                o_Pixel <= r_PB[31:30];
            end else begin
                // Word not here yet: emit blank pixels for this whole word.
                r_SR       <= 32'd0;
                o_Pixel    <= 2'd0;
                o_Underrun <= 1'b1;
            end
        end else if (w_Active) begin
            r_SR          <= {r_SR[29:0], 2'b00};
            o_Pixel       <= r_SR[29:28];
            o_Pixel_Valid <= 1'b1;
        end else begin
            o_Pixel       <= 2'd0;
            o_Pixel_Valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM and prefetch buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State     <= c_ST_IDLE;
            r_Fetch_Cnt <= '0;
            r_PB        <= 32'd0;
            r_PB_Full   <= 1'b0;
            r_Discard   <= 1'b0;
            o_Rd_Req    <= 1'b0;
            o_Rd_Addr   <= 12'd0;
        end else if (w_Resync) begin
            r_State     <= c_ST_IDLE;
            r_Fetch_Cnt <= '0;
            r_PB_Full   <= 1'b0;
            o_Rd_Req    <= 1'b0;
            // A response still owed by memory must be dropped when it comes.
            // If it lands in this very cycle it is simply ignored, so there
            // is nothing left to discard.
            r_Discard   <= ((r_State == c_ST_REQ) || r_Discard) && !i_Rd_Valid;
        end else begin
            if (r_Discard && i_Rd_Valid) begin
                r_Discard <= 1'b0;
            end
            // Consumption empties the buffer unless a capture below refills it
            // in the same cycle; the later assignment wins.
            if (w_Consume) begin
                r_PB_Full <= 1'b0;
            end
            case (r_State)
                c_ST_IDLE: begin
                    if (r_Fetch_Cnt == c_TOTAL) begin
                        r_State <= c_ST_DONE;
                    end else if (!r_PB_Full && !r_Discard) begin
                        r_State   <= c_ST_REQ;
                        o_Rd_Req  <= 1'b1;
                        o_Rd_Addr <= w_Next_Addr;
                    end
                end
                c_ST_REQ: begin
                    if (i_Rd_Valid) begin
                        r_PB        <= i_Rd_Data;
                        r_PB_Full   <= 1'b1;
                        r_Fetch_Cnt <= r_Fetch_Cnt + 1'b1;
                        r_State     <= c_ST_IDLE;
                        o_Rd_Req    <= 1'b0;
                    end
                end
                c_ST_DONE: begin
                    o_Rd_Req <= 1'b0;
                end
                default: begin
                    r_State  <= c_ST_IDLE;
                    o_Rd_Req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_framebuffer_reader
//  Purpose  : Directed self-checking bench for framebuffer_reader with a
//             behavioural pixel memory of programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_reader;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic [9:0]  i_Row;
    logic [9:0]  i_Column;
    logic        o_Rd_Req;
    logic [11:0] o_Rd_Addr;
    logic        i_Rd_Valid;
    logic [31:0] i_Rd_Data;
    logic [1:0]  o_Pixel;
    logic        o_Pixel_Valid;
    logic        o_Underrun;

    always #5 clk = ~clk;

    framebuffer_reader #(.X_START(16), .WIDTH(256), .HEIGHT(256)) u_dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_Row         (i_Row),
        .i_Column      (i_Column),
        .o_Rd_Req      (o_Rd_Req),
        .o_Rd_Addr     (o_Rd_Addr),
        .i_Rd_Valid    (i_Rd_Valid),
        .i_Rd_Data     (i_Rd_Data),
        .o_Pixel       (o_Pixel),
        .o_Pixel_Valid (o_Pixel_Valid),
        .o_Underrun    (o_Underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory contents: word 0 is the reference pattern, others encode the address.
    function automatic logic [31:0] mem_word(input logic [11:0] a);
        if (a == 12'd0) return 32'hE4E4E4E4;
        return {4'h9, a, ~a, 4'h6};
    endfunction

    function automatic logic [1:0] exp_pix(input int r, input int c);
        int          off;
        logic [31:0] w;
        off = c - 16;
        w   = mem_word(12'(r * 16 + off / 16));
        return 2'(w >> (30 - 2 * (off % 16)));
    endfunction

    // ---------------- behavioural memory ----------------
    int mem_latency = 0;
    int slow_addr   = -1;
    int slow_lat    = 40;
    int mem_addr    = 0;
    int mem_cnt     = 0;
    bit mem_busy    = 1'b0;
    bit mem_flush   = 1'b0;
    int req_count   = 0;
    int exp_addr    = 0;
    int order_err   = 0;
    int proto_err   = 0;

    always @(posedge clk) begin
        if (i_Reset) mem_flush = 1'b1;
    end

    always @(negedge clk) begin
        i_Rd_Valid = 1'b0;
        if (mem_flush) begin
            mem_busy  = 1'b0;
            mem_flush = 1'b0;
        end
        if (!mem_busy && o_Rd_Req) begin
            mem_addr = int'(o_Rd_Addr);
            req_count++;
            if (mem_addr != exp_addr) order_err++;
            exp_addr = mem_addr + 1;
            mem_cnt  = (mem_addr == slow_addr) ? slow_lat : mem_latency;
            mem_busy = 1'b1;
        end else if (mem_busy && o_Rd_Req && (int'(o_Rd_Addr) != mem_addr)) begin
            proto_err++;
        end
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                i_Rd_Valid = 1'b1;
                i_Rd_Data  = mem_word(12'(mem_addr));
                mem_busy   = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
    end

    // ---------------- scan driver ----------------
    int cur_row = 0, cur_col = 0, p_row = 0, p_col = 0;

    // After step returns, outputs correspond to (p_row, p_col).
    task automatic step(input int r, input int c);
        @(negedge clk);
        p_row    = cur_row;
        p_col    = cur_col;
        cur_row  = r;
        cur_col  = c;
        i_Row    = 10'(r);
        i_Column = 10'(c);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_req"},  32'(o_Rd_Req),      32'd0);
        check_eq({tag, "_rd_addr"}, 32'(o_Rd_Addr),     32'd0);
        check_eq({tag, "_pixel"},   32'(o_Pixel),       32'd0);
        check_eq({tag, "_pvalid"},  32'(o_Pixel_Valid), 32'd0);
        check_eq({tag, "_underrun"},32'(o_Underrun),    32'd0);
    endtask

    task automatic frame_check();
        if ((p_row == 0 || p_row == 1 || p_row == 128 || p_row == 255) &&
            p_col >= 16 && p_col <= 271)
            check_eq("frame_pixel", 32'(o_Pixel), 32'(exp_pix(p_row, p_col)));
        if (p_row == 255 && (p_col == 15 || p_col == 272))
            check_eq("edge_col_outside_valid", 32'(o_Pixel_Valid), 32'd0);
        if (p_row == 255 && (p_col == 16 || p_col == 271))
            check_eq("edge_col_inside_valid", 32'(o_Pixel_Valid), 32'd1);
        if (p_row == 256 && p_col == 25)
            check_eq("edge_row256_valid", 32'(o_Pixel_Valid), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int seen_at;
        i_Reset    = 1'b1;
        i_Row      = 10'd0;
        i_Column   = 10'd0;
        i_Rd_Valid = 1'b0;
        i_Rd_Data  = 32'd0;

        // ---- reset state ----
        step(0, 0); step(0, 0); step(0, 0);
        check_all_zero("reset");

        // ---- zero-wait memory, reference word 0 ----
        step(300, 0);
        i_Reset = 1'b0;
        step(300, 1);
        check_eq("first_req_after_reset", 32'(o_Rd_Req), 32'd1);
        check_eq("first_req_addr", 32'(o_Rd_Addr), 32'd0);
        for (int c = 2; c < 10; c++) step(300, c);
        for (int c = 14; c <= 24; c++) begin
            step(0, c);
            if (p_row == 0 && p_col == 15)
                check_eq("zw_col15_valid", 32'(o_Pixel_Valid), 32'd0);
            if (p_row == 0 && p_col >= 16 && p_col <= 19) begin
                check_eq("zw_pixel", 32'(o_Pixel), 32'(3 - (p_col - 16)));
                check_eq("zw_valid", 32'(o_Pixel_Valid), 32'd1);
                check_eq("zw_underrun", 32'(o_Underrun), 32'd0);
            end
        end

        // ---- full frame with 8-cycle memory ----
        step(300, 0);
        i_Reset     = 1'b1;
        mem_latency = 8;
        step(300, 1);
        i_Reset   = 1'b0;
        req_count = 0;
        exp_addr  = 0;
        order_err = 0;
        for (int c = 2; c < 22; c++) step(300, c);
        for (int r = 0; r < 256; r++) begin
            for (int c = 15; c <= 272; c++) begin
                step(r, c);
                frame_check();
            end
        end
        for (int c = 20; c < 45; c++) begin
            step(256, c);
            frame_check();
        end
        check_eq("frame_req_count", 32'(req_count), 32'd4096);
        check_eq("frame_order_errors", 32'(order_err), 32'd0);
        check_eq("frame_underrun", 32'(o_Underrun), 32'd0);
        check_eq("frame_done_no_req", 32'(o_Rd_Req), 32'd0);

        // ---- delayed word 5 -> underrun ----
        step(256, 0);
        mem_latency = 0;
        slow_addr   = 5;
        slow_lat    = 40;
        for (int c = 1; c < 10; c++) step(256, c);
        for (int c = 15; c <= 150; c++) begin
            step(0, c);
            if (c == 140) begin
                mem_latency = 40;
                slow_addr   = -1;
            end
            if (p_col == 95) begin
                check_eq("ur_col95_pixel", 32'(o_Pixel), 32'(exp_pix(0, 95)));
                check_eq("ur_col95_underrun", 32'(o_Underrun), 32'd0);
            end
            if (p_col >= 96 && p_col <= 111) begin
                check_eq("ur_blank_pixel", 32'(o_Pixel), 32'd0);
                check_eq("ur_blank_valid", 32'(o_Pixel_Valid), 32'd1);
            end
            if (p_col == 97 || p_col == 149)
                check_eq("ur_sticky", 32'(o_Underrun), 32'd1);
        end

        // ---- resync with a request in flight ----
        check_eq("resync_req_in_flight", 32'(o_Rd_Req), 32'd1);
        step(256, 0);
        mem_latency = 0;
        seen    = 1'b0;
        seen_at = 0;
        for (int c = 1; c < 80; c++) begin
            step(256, c);
            if (o_Rd_Req && !seen) begin
                seen    = 1'b1;
                seen_at = c;
                check_eq("post_resync_addr", 32'(o_Rd_Addr), 32'd0);
            end
        end
        check_eq("post_resync_req_seen", 32'(seen), 32'd1);
        check_eq("post_resync_waited_stale", 32'(seen_at > 20), 32'd1);
        for (int c = 14; c <= 22; c++) begin
            step(0, c);
            if (p_row == 0 && p_col >= 16 && p_col <= 19) begin
                check_eq("resync_pixel", 32'(o_Pixel), 32'(3 - (p_col - 16)));
                check_eq("resync_valid", 32'(o_Pixel_Valid), 32'd1);
                check_eq("resync_underrun", 32'(o_Underrun), 32'd1);
            end
        end
        check_eq("proto_errors", 32'(proto_err), 32'd0);

        // ---- reset mid-row during REQ ----
        step(256, 0);
        mem_latency = 8;
        for (int c = 1; c < 21; c++) step(256, c);
        for (int c = 15; c <= 100; c++) step(3, c);
        check_eq("pre_reset_in_req", 32'(o_Rd_Req), 32'd1);
        check_eq("pre_reset_underrun", 32'(o_Underrun), 32'd1);
        i_Reset = 1'b1;
        step(300, 0);
        check_all_zero("midrow_reset");
        i_Reset = 1'b0;
        step(300, 1);
        check_eq("post_reset_req", 32'(o_Rd_Req), 32'd1);
        check_eq("post_reset_addr", 32'(o_Rd_Addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
